// File: rtl/fft_output_reorder.sv
// Pair-to-serial reorder: bit-reversed pair writes into a ping-pong buffer, natural-order serial readout.
// Bin n leaves one cycle after its read; no backpressure -- a frame completing while the reader is busy is dropped (sticky o_overrun).
module fft_output_reorder #(
    parameter int LOG2N = 10,
    parameter int DW    = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_valid_in,
    input  logic [DW-1:0]    i_data_a_real,
    input  logic [DW-1:0]    i_data_a_imag,
    input  logic [DW-1:0]    i_data_b_real,
    input  logic [DW-1:0]    i_data_b_imag,
    output logic             o_valid_out,
    output logic [DW-1:0]    o_data_real,
    output logic [DW-1:0]    o_data_imag,
    output logic [LOG2N-1:0] o_index,
    output logic             o_last,
    output logic             o_overrun
);

    localparam int N  = 1 << LOG2N;
    localparam int HW = LOG2N - 1;

    logic [HW-1:0]    wr_cnt;
    logic [LOG2N-1:0] rd_cnt;
    logic             wr_bank;
    logic             rd_active;

    // Each half holds both banks: index = {bank, offset within half}.
    logic [2*DW-1:0]  mem_lo [N];
    logic [2*DW-1:0]  mem_hi [N];

    logic [HW-1:0]    wr_off;
    logic [LOG2N-1:0] wr_addr;
    logic [LOG2N-1:0] rd_addr;
    logic             frame_done;
    logic             rd_final;
    logic             frame_take;

    // bitrev({k,0}) has MSB 0, so its low bits are simply bitrev(k) over LOG2N-1 bits.
    always_comb begin
        wr_off = '0;
        for (int i = 0; i < HW; i++) begin
            wr_off[i] = wr_cnt[HW-1-i];
        end
    end

    assign wr_addr    = {wr_bank, wr_off};
    assign rd_addr    = {~wr_bank, rd_cnt[HW-1:0]};
    assign frame_done = i_valid_in && (&wr_cnt);
    assign rd_final   = rd_active && (&rd_cnt);
    assign frame_take = frame_done && (!rd_active || rd_final);

    always_ff @(posedge i_clk) begin
        if (i_valid_in) begin
            mem_lo[wr_addr] <= {i_data_a_real, i_data_a_imag};
            mem_hi[wr_addr] <= {i_data_b_real, i_data_b_imag};
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            wr_cnt      <= '0;
            rd_cnt      <= '0;
            wr_bank     <= 1'b0;
            rd_active   <= 1'b0;
            o_valid_out <= 1'b0;
            o_data_real <= '0;
            o_data_imag <= '0;
            o_index     <= '0;
            o_last      <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            if (i_valid_in) begin
                wr_cnt <= wr_cnt + 1'b1;
            end

            if (rd_active) begin
                rd_cnt <= rd_cnt + 1'b1;
                if (&rd_cnt) begin
                    rd_active <= 1'b0;
                end
            end

            // A new frame overrides the reader's end-of-frame stop on the same edge.
            if (frame_done) begin
                if (frame_take) begin
                    wr_bank   <= ~wr_bank;
                    rd_active <= 1'b1;
                    rd_cnt    <= '0;
                end else begin
                    o_overrun <= 1'b1;
                end
            end

            o_valid_out <= rd_active;
            o_last      <= rd_final;
            if (rd_active) begin
                o_index <= rd_cnt;
                if (rd_cnt[HW]) begin
                    {o_data_real, o_data_imag} <= mem_hi[rd_addr];
                end else begin
                    {o_data_real, o_data_imag} <= mem_lo[rd_addr];
                end
            end
        end
    end

endmodule

// File: tb/tb_fft_output_reorder.sv
// Directed bench for fft_output_reorder at N=1024: order, gapless streaming, overrun, gaps and reset.
module tb_fft_output_reorder;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_valid_in;
    logic [31:0] i_data_a_real, i_data_a_imag, i_data_b_real, i_data_b_imag;
    logic        o_valid_out;
    logic [31:0] o_data_real, o_data_imag;
    logic [9:0]  o_index;
    logic        o_last;
    logic        o_overrun;

    fft_output_reorder #(.LOG2N(10), .DW(32)) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_valid_in   (i_valid_in),
        .i_data_a_real(i_data_a_real),
        .i_data_a_imag(i_data_a_imag),
        .i_data_b_real(i_data_b_real),
        .i_data_b_imag(i_data_b_imag),
        .o_valid_out  (o_valid_out),
        .o_data_real  (o_data_real),
        .o_data_imag  (o_data_imag),
        .o_index      (o_index),
        .o_last       (o_last),
        .o_overrun    (o_overrun)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int          cyc;
        logic        last;
        logic [9:0]  idx;
        logic [31:0] re;
        logic [31:0] im;
    } samp_t;

    samp_t q[$];
    samp_t mon_s;
    int    cyc = 0;
    int    last_acc = 0;
    int    n_checks = 0;
    int    n_fail = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    always @(negedge i_clk) begin
        if (i_reset === 1'b1 && o_valid_out === 1'b1) begin
            mon_s.cyc  = cyc;
            mon_s.last = o_last;
            mon_s.idx  = o_index;
            mon_s.re   = o_data_real;
            mon_s.im   = o_data_imag;
            q.push_back(mon_s);
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int bitrev10(input int v);
        int r = 0;
        for (int i = 0; i < 10; i++) if (v[i]) r |= (1 << (9 - i));
        return r;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic pair(input int base, input int k);
        i_valid_in    = 1'b1;
        i_data_a_real = base + 2 * k;
        i_data_a_imag = -(base + 2 * k);
        i_data_b_real = base + 2 * k + 1;
        i_data_b_imag = -(base + 2 * k + 1);
        @(posedge i_clk);
        #1;
        i_valid_in = 1'b0;
        last_acc   = cyc;
    endtask

    // mode 0: every cycle, 1: every 2 cycles, 2: random idle gaps
    task automatic send(input int base, input int k0, input int k1, input int mode);
        for (int k = k0; k <= k1; k++) begin
            pair(base, k);
            if (mode == 1) idle(1);
            else if (mode == 2) while ($urandom_range(0, 9) < 4) idle(1);
        end
    endtask

    task automatic wait_out(input int n);
        int b = 0;
        while (q.size() < n && b < 4000) begin
            @(posedge i_clk);
            b++;
        end
        idle(8);
    endtask

    task automatic check_stream(input string tag, input int nfr, input int base0,
                                input int base1, input int first_cyc);
        logic [31:0] re_e, im_e;
        int n, base;
        check({tag, "_count"}, q.size(), nfr * 1024);
        if (q.size() > 0) check({tag, "_first_cyc"}, q[0].cyc, first_cyc);
        for (int i = 0; i < q.size() && i < nfr * 1024; i++) begin
            n    = i % 1024;
            base = (i < 1024) ? base0 : base1;
            re_e = base + bitrev10(n);
            im_e = -(base + bitrev10(n));
            check($sformatf("%s_s%0d", tag, i),
                  {16'(q[i].cyc - q[0].cyc), q[i].last, q[i].idx, q[i].re, q[i].im},
                  {16'(i), (n == 1023), 10'(n), re_e, im_e});
        end
        check({tag, "_valid_idle"}, o_valid_out, 1'b0);
    endtask

    task automatic chk_zero(input string tag);
        check(tag, {o_valid_out, o_data_real, o_data_imag, o_index, o_last, o_overrun}, '0);
    endtask

    initial begin
        int acc1;
        i_reset = 1'b0;
        i_valid_in = 1'b0;
        i_data_a_real = '0; i_data_a_imag = '0;
        i_data_b_real = '0; i_data_b_imag = '0;
        idle(3);
        chk_zero("reset_outs");
        i_reset = 1'b1;
        idle(2);
        chk_zero("post_reset_outs");

        // S1: single frame, one pair per 2 cycles
        q.delete();
        send(0, 0, 511, 1);
        wait_out(1024);
        check_stream("s1", 1, 0, 0, last_acc + 1);
        if (q.size() == 1024) begin
            check("s1_bin1",    q[1].re,    32'd512);
            check("s1_bin2",    q[2].re,    32'd256);
            check("s1_bin512",  q[512].re,  32'd1);
            check("s1_bin1023", q[1023].re, 32'd1023);
            check("s1_imag1",   q[1].im,    32'hFFFF_FE00);
            check("s1_last1022", q[1022].last, 1'b0);
        end
        check("s1_overrun", o_overrun, 1'b0);

        // S2: two frames back-to-back, gapless output
        q.delete();
        send(0, 0, 511, 1);
        acc1 = last_acc;
        send(4096, 0, 511, 1);
        wait_out(2048);
        check_stream("s2", 2, 0, 4096, acc1 + 1);
        check("s2_overrun", o_overrun, 1'b0);

        // S3: pairs every cycle for 3 frames, frame 2 dropped
        q.delete();
        send(0, 0, 511, 0);
        acc1 = last_acc;
        send(4096, 0, 510, 0);
        check("s3_ovr_pre", o_overrun, 1'b0);
        send(4096, 511, 511, 0);
        check("s3_ovr_post", o_overrun, 1'b1);
        send(8192, 0, 511, 0);
        wait_out(2048);
        check_stream("s3", 2, 0, 8192, acc1 + 1);
        check("s3_ovr_sticky", o_overrun, 1'b1);

        // S4: random input gaps within one frame
        i_reset = 1'b0;
        idle(2);
        chk_zero("s4_reset_outs");
        i_reset = 1'b1;
        idle(1);
        q.delete();
        send(0, 0, 511, 2);
        wait_out(1024);
        check_stream("s4", 1, 0, 0, last_acc + 1);
        check("s4_overrun", o_overrun, 1'b0);

        // S5: reset during pair 300, then a clean frame
        q.delete();
        send(20000, 0, 299, 1);
        i_valid_in    = 1'b1;
        i_data_a_real = 32'd20600;
        i_reset       = 1'b0;
        #1;
        chk_zero("s5_reset_async");
        for (int i = 0; i < 3; i++) begin
            idle(1);
            chk_zero($sformatf("s5_reset_hold%0d", i));
        end
        i_valid_in = 1'b0;
        i_reset    = 1'b1;
        idle(2);
        q.delete();
        send(0, 0, 511, 1);
        wait_out(1024);
        check_stream("s5", 1, 0, 0, last_acc + 1);
        check("s5_overrun", o_overrun, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
